// File: rtl/lfsr_pkg.sv
// Shared constants for the LFSR generator: digit width, default taps,
// hex-to-7-segment table (active-high {a,b,c,d,e,f,g,dp}).
package lfsr_pkg;

  localparam int DIGIT_W = 8;
  localparam logic [7:0] DEF_TAPS = 8'h1D;

  localparam logic [15:0][7:0] SEG_TAB = {
    8'h8E, 8'h9E, 8'h7A, 8'h9C,
    8'h3E, 8'hEE, 8'hF6, 8'hFE,
    8'hE0, 8'hBE, 8'hB6, 8'h66,
    8'hF2, 8'hDA, 8'h60, 8'hFC
  };

  // Display is active-low, dp stays dark.
  function automatic logic [DIGIT_W-1:0] seg_enc(
    input logic [3:0] v
  );
    return ~SEG_TAB[v];
  endfunction

endpackage

// File: rtl/lfsr_gen_edge_sync.sv
// Two-flop synchroniser plus rising-edge detector for the
// asynchronous step button.
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic [2:0] sh;

  always_ff @(posedge clk) begin
    if (rst) sh <= '0;
    else     sh <= {sh[1:0], d};
  end

  assign rise = sh[1] & ~sh[2];

endmodule

// File: rtl/lfsr_gen.sv
// Fibonacci LFSR with step/free-run control, period measurement and
// hex display. Define LFSR_LOCKUP_RECOVER_EN to escape the all-zero state.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int              WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(DEF_TAPS),
  parameter int              DIV   = 50_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [WIDTH-1:0]   seed_i,
  input  logic               step_i,
  input  logic               run_i,
  output logic [WIDTH-1:0]   state_o,
  output logic               zero_o,
  output logic [WIDTH-1:0]   period_o,
  output logic               period_vld_o,
  output logic [2*WIDTH-1:0] seg_o
);

  localparam int PW = $clog2(DIV);
  localparam int ND = WIDTH / 4;

`ifdef LFSR_LOCKUP_RECOVER_EN
  localparam bit RECOVER = 1'b1;
`else
  localparam bit RECOVER = 1'b0;
`endif

  function automatic logic [2*WIDTH-1:0] seg_word(
    input logic [WIDTH-1:0] v
  );
    logic [2*WIDTH-1:0] w;
    w = '0;
    for (int i = 0; i < ND; i++)
      w[DIGIT_W*i +: DIGIT_W] = seg_enc(v[4*i +: 4]);
    return w;
  endfunction

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] seed;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_inc;
  logic [WIDTH-1:0] nxt;
  logic [PW-1:0]    presc;
  logic             tick;
  logic             step_p;
  logic             adv;

  edge_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (step_i),
    .rise (step_p)
  );

  assign tick    = run_i && (presc == PW'(DIV - 1));
  assign adv     = step_p | tick;
  assign nxt     = {^(state & TAPS), state[WIDTH-1:1]};
  assign cnt_inc = cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst || !run_i) presc <= '0;
    else if (tick)     presc <= '0;
    else               presc <= presc + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= WIDTH'(1);
      seed         <= WIDTH'(1);
      cnt          <= '0;
      period_o     <= '0;
      period_vld_o <= 1'b0;
    end else begin
      period_vld_o <= 1'b0;
      if (load_i) begin
        state <= seed_i;
        seed  <= seed_i;
        cnt   <= '0;
      end else if (adv) begin
        if (RECOVER && state == '0) begin
          state <= WIDTH'(1);
          cnt   <= cnt_inc;
        end else begin
          state <= nxt;
          if (nxt == seed) begin
            period_o     <= cnt_inc;
            period_vld_o <= 1'b1;
            cnt          <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) seg_o <= seg_word(WIDTH'(1));
    else     seg_o <= seg_word(state);
  end

  assign state_o = state;
  assign zero_o  = (state == '0);

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen: stepping, free-run period,
// display, lock-up, load/reset priority.
module tb_lfsr_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_i;
  logic [7:0]  seed_i;
  logic        step_i;
  logic        run_i;
  logic [7:0]  state_o;
  logic        zero_o;
  logic [7:0]  period_o;
  logic        period_vld_o;
  logic [15:0] seg_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lfsr_gen #(
    .WIDTH (8),
    .TAPS  (8'h1D),
    .DIV   (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .load_i       (load_i),
    .seed_i       (seed_i),
    .step_i       (step_i),
    .run_i        (run_i),
    .state_o      (state_o),
    .zero_o       (zero_o),
    .period_o     (period_o),
    .period_vld_o (period_vld_o),
    .seg_o        (seg_o)
  );

  typedef struct {
    bit         ld;
    logic [7:0] seed;
    logic [7:0] exp;
    bit         ez;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [7:0] dig(input logic [3:0] v);
    logic [7:0] t [16];
    t = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
          8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};
    return t[v];
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(logic [7:0] s);
    @(negedge clk);
    load_i = 1'b1;
    seed_i = s;
    tick();
    @(negedge clk);
    load_i = 1'b0;
  endtask

  task automatic do_step();
    @(negedge clk);
    step_i = 1'b1;
    tick(3);
    @(negedge clk);
    step_i = 1'b0;
    tick(3);
  endtask

  int nvld;
  logic [7:0] per_s, st_s;

  initial begin
    rst = 1'b1; load_i = 0; seed_i = 0; step_i = 0; run_i = 0;
    tick(3);
    chk("rst_state", state_o, 8'h01);
    chk("rst_zero", zero_o, 1'b0);
    chk("rst_period", period_o, 8'h00);
    chk("rst_vld", period_vld_o, 1'b0);
    chk("rst_seg", seg_o, 16'h039F);
    @(negedge clk);
    rst = 1'b0;

    vecs.push_back('{1, 8'h01, 8'h01, 0});
    vecs.push_back('{0, 8'h00, 8'h80, 0});
    vecs.push_back('{0, 8'h00, 8'h40, 0});
    vecs.push_back('{0, 8'h00, 8'h20, 0});
    vecs.push_back('{0, 8'h00, 8'h10, 0});
    vecs.push_back('{0, 8'h00, 8'h88, 0});
    vecs.push_back('{1, 8'hC3, 8'hC3, 0});
    vecs.push_back('{0, 8'h00, 8'hE1, 0});
    vecs.push_back('{1, 8'h00, 8'h00, 1});
`ifdef LFSR_LOCKUP_RECOVER_EN
    vecs.push_back('{0, 8'h00, 8'h01, 0});
`else
    vecs.push_back('{0, 8'h00, 8'h00, 1});
`endif

    foreach (vecs[i]) begin
      if (vecs[i].ld) do_load(vecs[i].seed);
      else            do_step();
      chk($sformatf("vec%0d_state", i), state_o, vecs[i].exp);
      chk($sformatf("vec%0d_zero", i), zero_o, vecs[i].ez);
      tick();
      chk($sformatf("vec%0d_seg", i), seg_o,
          {dig(vecs[i].exp[7:4]), dig(vecs[i].exp[3:0])});
      if (vecs[i].exp == 8'h88)
        chk("seg_88", seg_o, 16'h0101);
    end

    // Held step: exactly one advance, on the third edge.
    do_load(8'h01);
    @(negedge clk);
    step_i = 1'b1;
    tick();
    chk("hold_e1", state_o, 8'h01);
    tick();
    chk("hold_e2", state_o, 8'h01);
    tick();
    chk("hold_e3", state_o, 8'h80);
    tick(97);
    chk("hold_100", state_o, 8'h80);
    @(negedge clk);
    step_i = 1'b0;
    tick(3);

    // Load wins over a step edge landing in the same cycle.
    @(negedge clk);
    step_i = 1'b1;
    tick(2);
    @(negedge clk);
    load_i = 1'b1;
    seed_i = 8'h5A;
    tick();
    chk("ldstep_state", state_o, 8'h5A);
    @(negedge clk);
    load_i = 1'b0;
    step_i = 1'b0;
    tick(4);
    chk("ldstep_hold", state_o, 8'h5A);

    // Free run from seed 1 for one full period.
    do_load(8'h01);
    run_i = 1'b1;
    nvld = 0;
    per_s = '0;
    st_s = '0;
    for (int c = 0; c < 530; c++) begin
      @(negedge clk);
      if (period_vld_o) begin
        nvld++;
        per_s = period_o;
        st_s = state_o;
      end
    end
    chk("run_vld_cnt", nvld, 1);
    chk("run_period", per_s, 8'd255);
    chk("run_state", st_s, 8'h01);
    chk("run_period_hold", period_o, 8'd255);

    // Reset in the middle of a free run.
    tick(7);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("mid_rst_state", state_o, 8'h01);
    chk("mid_rst_zero", zero_o, 1'b0);
    chk("mid_rst_period", period_o, 8'h00);
    chk("mid_rst_vld", period_vld_o, 1'b0);
    chk("mid_rst_seg", seg_o, 16'h039F);
    @(negedge clk);
    run_i = 1'b0;
    rst = 1'b0;
    tick(4);
    chk("post_rst_state", state_o, 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
